// File: rtl/usb_rcv_ctrl_if.sv
// Handshake bundle between the USB receive control unit and its neighbours
// (edge/EOP detectors, bit timer, shift register, receive FIFO).
interface usb_rcv_ctrl_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data,
    input  rcving, w_enable, r_error
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data,
    output rcving, w_enable, r_error
  );
endinterface

// File: rtl/usb_rcv_ctrl.sv
// USB full-speed receive control unit: sync check, FIFO write strobes, EOP and framing errors.
// Define USB_RCV_MAXLEN_EN to enforce a MAX_BYTES data-byte limit per packet.
module usb_rcv_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80
`ifdef USB_RCV_MAXLEN_EN
  , parameter int unsigned MAX_BYTES = 64
`endif
) (
  input logic         clk,
  input logic         n_rst,
  usb_rcv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, START, CHK_SYNC, RECV, STORE, EOP_WAIT, ERR
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       eop_pend_q, eop_pend_d;
  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic       r_error_q, r_error_d;
  logic       se_eop;
`ifdef USB_RCV_MAXLEN_EN
  logic [6:0] byte_cnt_q, byte_cnt_d;
`endif

  assign se_eop = bus.shift_enable & bus.eop;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    eop_pend_d = eop_pend_q;
`ifdef USB_RCV_MAXLEN_EN
    byte_cnt_d = byte_cnt_q;
`endif
    unique case (state_q)
      IDLE:     if (bus.d_edge) state_d = START;
      START: begin
        if (bus.byte_received) state_d = CHK_SYNC;
        else if (se_eop)       state_d = ERR;
      end
      CHK_SYNC: state_d = (bus.rcv_data == SYNC_BYTE) ? RECV : ERR;
      RECV: begin
        // byte_received wins over a coincident EOP sample; the EOP is deferred via eop_pend.
        if (bus.byte_received) begin
`ifdef USB_RCV_MAXLEN_EN
          if (byte_cnt_q == 7'(MAX_BYTES)) begin
            state_d = ERR;
          end else begin
            state_d    = STORE;
            eop_pend_d = se_eop;
          end
`else
          state_d    = STORE;
          eop_pend_d = se_eop;
`endif
        end else if (se_eop) begin
          state_d = (bit_cnt_q == '0) ? EOP_WAIT : ERR;
        end else if (bus.shift_enable) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STORE: begin
        state_d = eop_pend_q ? EOP_WAIT : RECV;
`ifdef USB_RCV_MAXLEN_EN
        byte_cnt_d = byte_cnt_q + 7'd1;
`endif
      end
      EOP_WAIT: if (bus.d_edge) state_d = IDLE;
      ERR:      if (se_eop)     state_d = EOP_WAIT;
      default:  state_d = IDLE;
    endcase

    if (bus.byte_received) bit_cnt_d = '0;
    if (state_d == START && state_q != START) begin
      bit_cnt_d = '0;
`ifdef USB_RCV_MAXLEN_EN
      byte_cnt_d = '0;
`endif
    end
    if (state_d == EOP_WAIT) eop_pend_d = 1'b0;

    rcving_d   = (state_d != IDLE);
    w_enable_d = (state_d == STORE);
    r_error_d  = r_error_q;
    if (state_q == IDLE && bus.d_edge) r_error_d = 1'b0;
    if (state_d == ERR)                r_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      eop_pend_q <= 1'b0;
      rcving_q   <= 1'b0;
      w_enable_q <= 1'b0;
      r_error_q  <= 1'b0;
`ifdef USB_RCV_MAXLEN_EN
      byte_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      eop_pend_q <= eop_pend_d;
      rcving_q   <= rcving_d;
      w_enable_q <= w_enable_d;
      r_error_q  <= r_error_d;
`ifdef USB_RCV_MAXLEN_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

  assign bus.rcving   = rcving_q;
  assign bus.w_enable = w_enable_q;
  assign bus.r_error  = r_error_q;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Randomized packet-level bench for usb_rcv_ctrl against a transaction-level model
// (expected FIFO writes and error flag derived per packet from the packet contents).
module tb_usb_rcv_ctrl;

  logic clk = 1'b0;
  logic n_rst;
  usb_rcv_ctrl_if bus();

`ifdef USB_RCV_MAXLEN_EN
  localparam int unsigned LIMIT = 2;
  usb_rcv_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
`else
  localparam int unsigned LIMIT = 32'hFFFF_FFFF;
  usb_rcv_ctrl #(.SYNC_BYTE(8'h80)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [7:0] got_q[$];
  logic [7:0] pkt_q[$];

  always @(negedge clk)
    if (n_rst && bus.w_enable) got_q.push_back(bus.rcv_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    cyc();
    cyc();
  endtask

  task automatic shift(input logic with_eop, input logic allow_edge);
    gap();
    bus.eop          = with_eop;
    bus.shift_enable = 1'b1;
    bus.d_edge       = allow_edge && ($urandom_range(0, 3) == 0);
    cyc();
    bus.shift_enable = 1'b0;
    bus.d_edge       = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic simul_eop);
    for (int i = 0; i < 8; i++) shift(1'b0, 1'b1);
    bus.byte_received = 1'b1;
    bus.rcv_data      = b;
    if (simul_eop) begin
      bus.shift_enable = 1'b1;
      bus.eop          = 1'b1;
    end
    cyc();
    bus.byte_received = 1'b0;
    bus.shift_enable  = 1'b0;
  endtask

  task automatic pulse_edge();
    bus.d_edge = 1'b1;
    cyc();
    bus.d_edge = 1'b0;
  endtask

  // mode: 0 EOP on byte boundary, 1 EOP after k stray bits, 2 EOP with last byte_received,
  // 3 EOP during the sync byte after k bits.
  task automatic run_pkt(input logic [7:0] sync, input int unsigned mode_in, input int unsigned k);
    int unsigned mode;
    logic        exp_err;
    logic [7:0]  exp_w[$];
    mode = (mode_in == 2 && pkt_q.size() == 0) ? 0 : mode_in;

    exp_err = (mode == 3) || (sync != 8'h80);
    if (!exp_err) begin
      foreach (pkt_q[i]) begin
        if (i < LIMIT) exp_w.push_back(pkt_q[i]);
        else exp_err = 1'b1;
      end
      if (mode == 1) exp_err = 1'b1;
    end

    got_q.delete();
    pulse_edge();
    chk("start_rcving", {31'd0, bus.rcving}, 32'd1);
    chk("start_rerr_clr", {31'd0, bus.r_error}, 32'd0);

    if (mode == 3) begin
      for (int i = 0; i < int'(k); i++) shift(1'b0, 1'b1);
    end else begin
      send_byte(sync, 1'b0);
      cyc();
      chk("sync_rerr", {31'd0, bus.r_error}, {31'd0, sync != 8'h80});
      foreach (pkt_q[i]) send_byte(pkt_q[i], mode == 2 && i == pkt_q.size() - 1);
      if (mode == 1) for (int i = 0; i < int'(k); i++) shift(1'b0, 1'b0);
    end

    if (mode != 2) shift(1'b1, 1'b0);
    shift(1'b1, 1'b0);
    gap();
    bus.eop = 1'b0;
    cyc();

    chk("eopw_rcving", {31'd0, bus.rcving}, 32'd1);
    chk("eopw_rerr", {31'd0, bus.r_error}, {31'd0, exp_err});
    chk("n_writes", got_q.size(), exp_w.size());
    foreach (exp_w[i])
      if (i < got_q.size()) chk("wdata", {24'd0, got_q[i]}, {24'd0, exp_w[i]});

    pulse_edge();
    chk("idle_rcving", {31'd0, bus.rcving}, 32'd0);
    gap();
    chk("idle_rerr_sticky", {31'd0, bus.r_error}, {31'd0, exp_err});
    chk("idle_wen", {31'd0, bus.w_enable}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.d_edge = 1'b0; bus.eop = 1'b0; bus.shift_enable = 1'b0;
    bus.byte_received = 1'b0; bus.rcv_data = 8'h00;
    n_rst = 1'b0;
    cyc(); cyc();
    chk("rst_rcving", {31'd0, bus.rcving}, 32'd0);
    chk("rst_wen", {31'd0, bus.w_enable}, 32'd0);
    chk("rst_rerr", {31'd0, bus.r_error}, 32'd0);
    n_rst = 1'b1;
    cyc();

    pkt_q = '{8'hA5, 8'h3C};       run_pkt(8'h80, 0, 0);
    pkt_q = '{8'h55};              run_pkt(8'h81, 0, 0);
    pkt_q = '{8'h11};              run_pkt(8'h80, 1, 3);
    pkt_q = '{8'h7E};              run_pkt(8'h80, 2, 0);
    pkt_q = '{8'h01, 8'h02, 8'h03}; run_pkt(8'h80, 0, 0);
    pkt_q = {};                    run_pkt(8'h80, 3, 4);

    // Reset in the middle of a data byte
    pulse_edge();
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 4; i++) shift(1'b0, 1'b0);
    chk("pre_rst_rcving", {31'd0, bus.rcving}, 32'd1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("async_rst_rcving", {31'd0, bus.rcving}, 32'd0);
    chk("async_rst_wen", {31'd0, bus.w_enable}, 32'd0);
    chk("async_rst_rerr", {31'd0, bus.r_error}, 32'd0);
    cyc();
    n_rst = 1'b1;
    cyc();
    chk("post_rst_rcving", {31'd0, bus.rcving}, 32'd0);
    pkt_q = '{8'hC3, 8'h96};       run_pkt(8'h80, 0, 0);

    for (int p = 0; p < 40; p++) begin
      logic [7:0]  sync;
      int unsigned mode, nb, k;
      sync = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
      nb   = $urandom_range(0, 4);
      mode = $urandom_range(0, 3);
      k    = (mode == 3) ? $urandom_range(0, 7) : $urandom_range(1, 7);
      pkt_q.delete();
      for (int i = 0; i < int'(nb); i++) pkt_q.push_back(8'($urandom));
      run_pkt(sync, mode, k);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
